// File: rtl/vblank_update_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vblank_update_scheduler_pkg
// Shared definitions for the vertical-blank update scheduler:
//   - scheduler state encoding
//   - default client count, grant-index width and watchdog limit
//   - 1024x768 display timing constants, also used by the timing generator
//   - width helper for the optional watchdog counter
// -----------------------------------------------------------------------------
package vblank_update_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } sched_state_e;

    localparam int unsigned DEF_N_CLIENTS      = 32'd4;
    localparam int unsigned DEF_GID_W          = 32'd2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd4096;

    // 1024x768 timing: totals and the pixel/line where blanking begins.
    localparam int unsigned H_TOTAL       = 32'd1344;
    localparam int unsigned V_TOTAL       = 32'd806;
    localparam int unsigned H_BLANK_START = 32'd1024;
    localparam int unsigned V_BLANK_START = 32'd768;
    localparam int unsigned VBLANK_CYCLES = (V_TOTAL - V_BLANK_START) * H_TOTAL;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/vblank_update_scheduler_lowest_bit_sel.sv
// -----------------------------------------------------------------------------
// lowest_bit_sel
// Combinational priority encoder: picks the lowest set bit of vec_i.
// Ports:
//   vec_i    [N-1:0]  candidate vector
//   onehot_o [N-1:0]  one-hot of the lowest set bit (all zero if vec_i == 0)
//   idx_o    [W-1:0]  index of the lowest set bit (0 if vec_i == 0)
// -----------------------------------------------------------------------------
module lowest_bit_sel #(
    parameter int unsigned N = 32'd4,
    parameter int unsigned W = 32'd2
) (
    input  logic [N-1:0] vec_i,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o
);

    logic found_s;

    // Scan upward; the first set bit wins and masks all higher ones.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_s  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (vec_i[i] && !found_s) begin
                onehot_o[i] = 1'b1;
                idx_o       = W'(i);
                found_s     = 1'b1;
            end else begin
                onehot_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vblank_update_scheduler.sv
// -----------------------------------------------------------------------------
// vblank_update_scheduler
// Runs game-state update clients one at a time inside vertical blanking.
// At each blank start the requesting clients are latched, then granted in
// ascending index order with a start pulse / done handshake. Work left when
// blanking ends is aborted and flagged so the visible frame never sees a
// half-updated state.
//
// Optional feature macro: SCHED_TIMEOUT_EN adds a per-client watchdog that
// skips a client stuck in WAIT for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk_in     pixel clock (shared with the timing generator)
//   rst        synchronous, active-high reset
//   vblnk_in   registered vertical blank
//   req        per-client level request
//   done       per-client completion pulse
//   clr_flags  clears sticky overrun / timeout
//   start      one-hot start pulse to the granted client
//   grant_id   index of the granted client
//   busy       high while a client is granted
//   abort      one-cycle pulse when a schedule or client is cut short
//   overrun    sticky: schedule unfinished at end of blank
//   timeout    sticky: a client hit the watchdog (0 without the macro)
//   frame_cnt  number of blank starts seen, wrapping
// -----------------------------------------------------------------------------
module vblank_update_scheduler
    import vblank_update_scheduler_pkg::*;
#(
    parameter int unsigned N_CLIENTS      = DEF_N_CLIENTS,
    parameter int unsigned GID_W          = DEF_GID_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 vblnk_in,
    input  logic [N_CLIENTS-1:0] req,
    input  logic [N_CLIENTS-1:0] done,
    input  logic                 clr_flags,
    output logic [N_CLIENTS-1:0] start,
    output logic [GID_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 abort,
    output logic                 overrun,
    output logic                 timeout,
    output logic [15:0]          frame_cnt
);

    sched_state_e           state_q, state_d;
    logic                   vblnk_q;
    logic [N_CLIENTS-1:0]   pending_q, pending_d;
    logic [GID_W-1:0]       grant_id_q, grant_id_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   overrun_q, overrun_d;

    logic                   rise_s;
    logic                   grant_done_s;
    logic [N_CLIENTS-1:0]   sel_onehot_s;
    logic [GID_W-1:0]       sel_idx_s;
    logic [N_CLIENTS-1:0]   start_s;
    logic                   abort_s;
    logic                   set_overrun_s;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   set_timeout_s;
    logic                   to_expire_s;

    assign to_expire_s = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 32'd1));
`else
    logic [31:0]            timeout_unused_s;

    assign timeout_unused_s = 32'(TIMEOUT_CYCLES);
`endif

    // vblnk_q resets high so leaving reset mid-blank cannot look like a rise.
    assign rise_s       = vblnk_in & ~vblnk_q;
    assign grant_done_s = done[grant_id_q];

    lowest_bit_sel #(
        .N (N_CLIENTS),
        .W (GID_W)
    ) u_sel (
        .vec_i    (pending_q),
        .onehot_o (sel_onehot_s),
        .idx_o    (sel_idx_s)
    );

    // State, edge-detect and flag registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vblnk_q     <= 1'b1;
            pending_q   <= '0;
            grant_id_q  <= '0;
            frame_cnt_q <= 16'd0;
            overrun_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            vblnk_q     <= vblnk_in;
            pending_q   <= pending_d;
            grant_id_q  <= grant_id_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
`ifdef SCHED_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next-state, grant and flag logic.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        grant_id_d    = grant_id_q;
        frame_cnt_d   = frame_cnt_q;
        start_s       = '0;
        abort_s       = 1'b0;
        set_overrun_s = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        set_timeout_s = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    pending_d   = req;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_SELECT;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_SELECT: begin
                if (!vblnk_in) begin
                    // Blank over before the next grant: anything left is lost.
                    abort_s       = 1'b1;
                    set_overrun_s = (pending_q != '0);
                    pending_d     = '0;
                    state_d       = ST_IDLE;
                end else if (pending_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    start_s    = sel_onehot_s;
                    grant_id_d = sel_idx_s;
                    pending_d  = pending_q & ~sel_onehot_s;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!vblnk_in) begin
                    // A done arriving with the blank end still counts as
                    // complete; only unserved clients make it an overrun.
                    abort_s       = 1'b1;
                    set_overrun_s = !grant_done_s || (pending_q != '0);
                    pending_d     = '0;
                    state_d       = ST_IDLE;
                end else if (grant_done_s) begin
                    state_d = ST_SELECT;
`ifdef SCHED_TIMEOUT_EN
                end else if (to_expire_s) begin
                    // Skip the stuck client; the frame carries on.
                    abort_s       = 1'b1;
                    set_timeout_s = 1'b1;
                    state_d       = ST_SELECT;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                if (!vblnk_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sticky flags: a same-cycle set beats the clear.
        if (set_overrun_s) begin
            overrun_d = 1'b1;
        end else if (clr_flags) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

`ifdef SCHED_TIMEOUT_EN
        if (set_timeout_s) begin
            timeout_d = 1'b1;
        end else if (clr_flags) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end

        // Counter is zero in the first WAIT cycle of each grant.
        if ((state_q != ST_WAIT) && (state_d == ST_WAIT)) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end
`endif
    end

    assign start     = start_s;
    assign abort     = abort_s;
    assign busy      = (state_q == ST_WAIT);
    assign grant_id  = grant_id_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
`ifdef SCHED_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule
